exception_commit: RTL and testbench
===================================

# exception_commit

MEM-stage consumer of the per-instruction exception vector built up through IF/ID/EXE. It resolves the highest-priority exception or pseudo-exception (Eret, Refetch) carried by the instruction in MEM, and flushes the pipeline. It updates the CP0 exception registers it owns (EPC, BadVAddr, Cause.ExcCode/BD, Status.EXL), then hands a redirect PC to IF over a valid/ready handshake.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- MEM_Valid  in  1  MEM holds a live instruction
- MEM_ExceptType  in  ExceptinPipeType  final exception vector from EXE (19 flags)
- MEM_PC  in  32  PC of MEM instruction
- MEM_InDelaySlot  in  1  MEM instruction is in a branch delay slot
- MEM_DataAddr  in  32  effective data address
- WB_CP0We  in  1  MTC0 write from older instruction in WB
- WB_CP0Addr  in  5  CP0 register number
- WB_CP0Data  in  32  MTC0 data
- Flush_All  out  1  kill IF..MEM same cycle (combinational)
- Redirect_Valid  out  1  redirect request to IF
- Redirect_PC  out  32  target PC, stable while Redirect_Valid
- IF_RedirectReady  in  1  IF accepts redirect
- CP0_EPC, CP0_BadVAddr, CP0_Cause, CP0_Status  out  32 each  owned-field views; unowned bits read 0

## Operation
- Commit = MEM_Valid & !pending & any flag set. Priority, high to low:
  1. Interrupt (0)
  2. WrongAddressinIF (AdEL 4)
  3. TLBRefillinIF / TLBInvalidinIF (TLBL 2)
  4. ReservedInstruction (10)
  5. CoprocessorUnusable (11)
  6. Syscall (8), Break (9), Overflow (12), Trap (13), in that order
  7. RdWrongAddressinMEM (4), WrWrongAddressinMEM (AdES 5)
  8. RdTLBRefill/Invalid (2), WrTLBRefill/Invalid (TLBS 3)
  9. TLBModified (1)
  10. Eret
  11. Refetch
- Real exception:
  - Cause.ExcCode = code.
  - If EXL=0: EPC = InDelaySlot ? PC-4 : PC; Cause.BD = InDelaySlot. If EXL=1 (nested), EPC and BD are unchanged.
  - EXL = 1.
  - Redirect_PC = 0xBFC00200 + offset. Offset is 0x000 only for a TLB refill with EXL=0, else 0x180.
- BadVAddr:
  - IF address/TLB exceptions: MEM_PC.
  - MEM address/TLB/Mod exceptions: MEM_DataAddr.
  - Otherwise unchanged.
- Eret: EXL = 0; Redirect_PC = EPC (value after any same-cycle WB MTC0 to EPC); Cause untouched.
- Refetch: Redirect_PC = MEM_PC; no CP0 change.
- MTC0 writable fields:
  - reg 12: bit 1 (EXL)
  - reg 14: all 32 bits
  - reg 13: ExcCode/BD are not writable
  - reg 8 and all others: ignored.
- Same cycle as commit: MTC0 applies first, commit overrides the fields it writes.
- States: IDLE, PENDING.
  - IDLE→PENDING on commit.
  - PENDING→IDLE on IF_RedirectReady.
  - MEM_Valid during PENDING is ignored; upstream flush guarantees it never occurs, and the bench asserts this.

## Timing
- Reset values: all CP0 outputs 0, EXL 0, Flush_All 0, Redirect_Valid 0, Redirect_PC 0, state IDLE.
- Cycle N (commit): Flush_All=1 combinationally; CP0 registers update at end of N.
- Redirect_Valid=1 from N+1 and held, with Redirect_PC stable, until the cycle IF_RedirectReady=1. It drops the next cycle, so IDLE is reached at earliest in N+2.
- A new commit is accepted in the first IDLE cycle.
- rst mid-PENDING: Redirect_Valid drops the next edge; the redirect is lost.
- EPC-4 wraps modulo 2^32 (PC=0 with BD gives 0xFFFFFFFC).

## Configuration
- EXC_REFETCH_EN defined: Refetch flag is handled as above.
- EXC_REFETCH_EN undefined: Refetch is ignored. It does not commit, flush or redirect; the instruction retires normally.

## Test plan
- Overflow at PC 0x80001000, no delay slot, EXL=0 -> Flush_All in N; EPC=0x80001000, ExcCode=12, EXL=1; Redirect_PC=0xBFC00380 from N+1.
- Load address error at data address 0x80002001, PC 0x80001004 in delay slot -> ExcCode=4, BD=1, EPC=0x80001000, BadVAddr=0x80002001.
- WrTLBRefill with EXL=0 -> Redirect_PC=0xBFC00200, ExcCode=3. Repeat with EXL=1 -> 0xBFC00380, EPC unchanged.
- Interrupt plus Syscall plus RdWrongAddressinMEM together -> ExcCode=0 only, BadVAddr unchanged.
- Eret with EPC=0x80000100; IF_RedirectReady low for 3 cycles -> Redirect_Valid held 3 cycles with PC 0x80000100, EXL=0, idle after accept.
- Refetch at PC 0x80003000: with EXC_REFETCH_EN -> Redirect_PC=0x80003000, CP0 unchanged; without -> no Flush_All.

Source files
------------

// File: rtl/exception_commit.sv
// exception_commit
//
// MEM-stage exception commit unit. Resolves the highest-priority exception
// or pseudo-exception (Eret, Refetch) carried by the instruction in MEM.
// On a commit it does three things:
//   - kills IF..MEM in the same cycle,
//   - updates the CP0 exception fields this block owns,
//   - hands a redirect PC to IF over a valid/ready handshake.
//
// Optional feature macro: EXC_REFETCH_EN
//   defined   : the Refetch flag commits, flushes and redirects to MEM_PC.
//   undefined : the Refetch flag is ignored and the instruction retires normally.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   MEM_Valid          MEM holds a live instruction
//   MEM_ExceptType     19 exception flags. Bit order:
//                         0 Interrupt             1 WrongAddressinIF
//                         2 TLBRefillinIF         3 TLBInvalidinIF
//                         4 ReservedInstruction   5 CoprocessorUnusable
//                         6 Syscall               7 Break
//                         8 Overflow              9 Trap
//                        10 RdWrongAddressinMEM  11 WrWrongAddressinMEM
//                        12 RdTLBRefillinMEM     13 RdTLBInvalidinMEM
//                        14 WrTLBRefillinMEM     15 WrTLBInvalidinMEM
//                        16 TLBModified          17 Eret
//                        18 Refetch
//   MEM_PC             PC of the MEM instruction
//   MEM_InDelaySlot    MEM instruction sits in a branch delay slot
//   MEM_DataAddr       effective data address of the MEM instruction
//   WB_CP0We           MTC0 write enable from the older instruction in WB
//   WB_CP0Addr         MTC0 CP0 register number
//   WB_CP0Data         MTC0 write data
//   Flush_All          combinational kill of IF..MEM on a commit
//   Redirect_Valid     redirect request to IF
//   Redirect_PC        redirect target; stable while Redirect_Valid is high
//   IF_RedirectReady   IF accepts the redirect
//   CP0_EPC            EPC (all 32 bits)
//   CP0_BadVAddr       BadVAddr (all 32 bits)
//   CP0_Cause          Cause view: BD in bit 31, ExcCode in bits 6:2, others 0
//   CP0_Status         Status view: EXL in bit 1, others 0
//
// FSM
//   state   | meaning
//   IDLE    | waiting for a commit from MEM
//   PENDING | redirect offered to IF, waiting for IF_RedirectReady

module exception_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [18:0] MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_InDelaySlot,
    input  logic [31:0] MEM_DataAddr,
    input  logic        WB_CP0We,
    input  logic [4:0]  WB_CP0Addr,
    input  logic [31:0] WB_CP0Data,
    output logic        Flush_All,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    input  logic        IF_RedirectReady,
    output logic [31:0] CP0_EPC,
    output logic [31:0] CP0_BadVAddr,
    output logic [31:0] CP0_Cause,
    output logic [31:0] CP0_Status
);

    localparam int ExInt        = 0;
    localparam int ExAdelIf     = 1;
    localparam int ExTlbRefIf   = 2;
    localparam int ExTlbInvIf   = 3;
    localparam int ExRi         = 4;
    localparam int ExCpu        = 5;
    localparam int ExSys        = 6;
    localparam int ExBp         = 7;
    localparam int ExOv         = 8;
    localparam int ExTr         = 9;
    localparam int ExRdAdr      = 10;
    localparam int ExWrAdr      = 11;
    localparam int ExRdTlbRef   = 12;
    localparam int ExRdTlbInv   = 13;
    localparam int ExWrTlbRef   = 14;
    localparam int ExWrTlbInv   = 15;
    localparam int ExMod        = 16;
    localparam int ExEret       = 17;
    localparam int ExRefetch    = 18;

    localparam logic [4:0] CodeInt  = 5'd0;
    localparam logic [4:0] CodeMod  = 5'd1;
    localparam logic [4:0] CodeTlbl = 5'd2;
    localparam logic [4:0] CodeTlbs = 5'd3;
    localparam logic [4:0] CodeAdel = 5'd4;
    localparam logic [4:0] CodeAdes = 5'd5;
    localparam logic [4:0] CodeSys  = 5'd8;
    localparam logic [4:0] CodeBp   = 5'd9;
    localparam logic [4:0] CodeRi   = 5'd10;
    localparam logic [4:0] CodeCpu  = 5'd11;
    localparam logic [4:0] CodeOv   = 5'd12;
    localparam logic [4:0] CodeTr   = 5'd13;

    localparam logic [31:0] VectorBase    = 32'hBFC0_0200;
    localparam logic [31:0] GeneralOffset = 32'h0000_0180;

    localparam logic [4:0] RegStatus = 5'd12;
    localparam logic [4:0] RegEpc    = 5'd14;

    typedef enum logic [1:0] {
        BadKeep,
        BadFromPc,
        BadFromData
    } BadSelType;

    typedef enum logic [0:0] {
        IDLE,
        PENDING
    } StateType;

    StateType    state, stateNext;

    logic        exl, exlNext;
    logic        bd, bdNext;
    logic [4:0]  excCode, excCodeNext;
    logic [31:0] epc, epcNext;
    logic [31:0] badVAddr, badVAddrNext;
    logic [31:0] redirectPc, redirectPcNext;

    logic [18:0] flags;
    logic        commit;
    logic        isReal;
    logic        isEret;
    logic        isRefill;
    logic [4:0]  resolvedCode;
    BadSelType   badSel;

    logic        exlAfterWb;
    logic [31:0] epcAfterWb;

    // Refetch only participates when the feature is built in; otherwise the
    // flag is invisible to both the commit condition and the priority chain.
    always_comb begin
        flags = MEM_ExceptType;
`ifdef EXC_REFETCH_EN
        flags[ExRefetch] = MEM_ExceptType[ExRefetch];
`else
        flags[ExRefetch] = 1'b0;
`endif
    end

    assign commit = MEM_Valid && (state == IDLE) && (|flags);

    // MTC0 from WB is older than the MEM instruction, so its effect is applied
    // first and everything below (nesting check, Eret target) sees it.
    always_comb begin
        exlAfterWb = exl;
        epcAfterWb = epc;
        if (WB_CP0We) begin
            case (WB_CP0Addr)
                RegStatus: exlAfterWb = WB_CP0Data[1];
                RegEpc:    epcAfterWb = WB_CP0Data;
                default:   ;
            endcase
        end
    end

    always_comb begin
        isReal       = 1'b1;
        isEret       = 1'b0;
        isRefill     = 1'b0;
        resolvedCode = CodeInt;
        badSel       = BadKeep;
        if (flags[ExInt]) begin
            resolvedCode = CodeInt;
        end else if (flags[ExAdelIf]) begin
            resolvedCode = CodeAdel;
            badSel       = BadFromPc;
        end else if (flags[ExTlbRefIf] || flags[ExTlbInvIf]) begin
            resolvedCode = CodeTlbl;
            badSel       = BadFromPc;
            isRefill     = flags[ExTlbRefIf];
        end else if (flags[ExRi]) begin
            resolvedCode = CodeRi;
        end else if (flags[ExCpu]) begin
            resolvedCode = CodeCpu;
        end else if (flags[ExSys]) begin
            resolvedCode = CodeSys;
        end else if (flags[ExBp]) begin
            resolvedCode = CodeBp;
        end else if (flags[ExOv]) begin
            resolvedCode = CodeOv;
        end else if (flags[ExTr]) begin
            resolvedCode = CodeTr;
        end else if (flags[ExRdAdr]) begin
            resolvedCode = CodeAdel;
            badSel       = BadFromData;
        end else if (flags[ExWrAdr]) begin
            resolvedCode = CodeAdes;
            badSel       = BadFromData;
        end else if (flags[ExRdTlbRef] || flags[ExRdTlbInv]) begin
            resolvedCode = CodeTlbl;
            badSel       = BadFromData;
            isRefill     = flags[ExRdTlbRef];
        end else if (flags[ExWrTlbRef] || flags[ExWrTlbInv]) begin
            resolvedCode = CodeTlbs;
            badSel       = BadFromData;
            isRefill     = flags[ExWrTlbRef];
        end else if (flags[ExMod]) begin
            resolvedCode = CodeMod;
            badSel       = BadFromData;
        end else if (flags[ExEret]) begin
            isReal = 1'b0;
            isEret = 1'b1;
        end else begin
            // Refetch (or no flag at all, in which case commit is low anyway)
            isReal = 1'b0;
        end
    end

    always_comb begin
        exlNext        = exlAfterWb;
        epcNext        = epcAfterWb;
        bdNext         = bd;
        excCodeNext    = excCode;
        badVAddrNext   = badVAddr;
        redirectPcNext = redirectPc;
        if (commit) begin
            if (isReal) begin
                excCodeNext = resolvedCode;
                // Nested exceptions keep the EPC/BD of the outer one.
                if (!exlAfterWb) begin
                    epcNext = MEM_InDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
                    bdNext  = MEM_InDelaySlot;
                end
                exlNext = 1'b1;
                case (badSel)
                    BadFromPc:   badVAddrNext = MEM_PC;
                    BadFromData: badVAddrNext = MEM_DataAddr;
                    default:     ;
                endcase
                // Only a first-level TLB refill uses the dedicated vector.
                if (isRefill && !exlAfterWb) begin
                    redirectPcNext = VectorBase;
                end else begin
                    redirectPcNext = VectorBase + GeneralOffset;
                end
            end else if (isEret) begin
                exlNext        = 1'b0;
                redirectPcNext = epcAfterWb;
            end else begin
                redirectPcNext = MEM_PC;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (commit) stateNext = PENDING;
            PENDING: if (IF_RedirectReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            exl        <= 1'b0;
            bd         <= 1'b0;
            excCode    <= 5'd0;
            epc        <= 32'd0;
            badVAddr   <= 32'd0;
            redirectPc <= 32'd0;
        end else begin
            state      <= stateNext;
            exl        <= exlNext;
            bd         <= bdNext;
            excCode    <= excCodeNext;
            epc        <= epcNext;
            badVAddr   <= badVAddrNext;
            redirectPc <= redirectPcNext;
        end
    end

    assign Flush_All      = commit;
    assign Redirect_Valid = (state == PENDING);
    assign Redirect_PC    = redirectPc;
    assign CP0_EPC        = epc;
    assign CP0_BadVAddr   = badVAddr;
    assign CP0_Cause      = {bd, 24'd0, excCode, 2'b00};
    assign CP0_Status     = {30'd0, exl, 1'b0};

endmodule

// File: tb/tb_exception_commit.sv
module tb_exception_commit;

    logic        clk;
    logic        rst;
    logic        MEM_Valid;
    logic [18:0] MEM_ExceptType;
    logic [31:0] MEM_PC;
    logic        MEM_InDelaySlot;
    logic [31:0] MEM_DataAddr;
    logic        WB_CP0We;
    logic [4:0]  WB_CP0Addr;
    logic [31:0] WB_CP0Data;
    logic        Flush_All;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        IF_RedirectReady;
    logic [31:0] CP0_EPC;
    logic [31:0] CP0_BadVAddr;
    logic [31:0] CP0_Cause;
    logic [31:0] CP0_Status;

    exception_commit dut (
        .clk             (clk),
        .rst             (rst),
        .MEM_Valid       (MEM_Valid),
        .MEM_ExceptType  (MEM_ExceptType),
        .MEM_PC          (MEM_PC),
        .MEM_InDelaySlot (MEM_InDelaySlot),
        .MEM_DataAddr    (MEM_DataAddr),
        .WB_CP0We        (WB_CP0We),
        .WB_CP0Addr      (WB_CP0Addr),
        .WB_CP0Data      (WB_CP0Data),
        .Flush_All       (Flush_All),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_PC     (Redirect_PC),
        .IF_RedirectReady(IF_RedirectReady),
        .CP0_EPC         (CP0_EPC),
        .CP0_BadVAddr    (CP0_BadVAddr),
        .CP0_Cause       (CP0_Cause),
        .CP0_Status      (CP0_Status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [18:0] F_INT   = 19'd1 << 0;
    localparam logic [18:0] F_TLBRI = 19'd1 << 2;
    localparam logic [18:0] F_RI    = 19'd1 << 4;
    localparam logic [18:0] F_CPU   = 19'd1 << 5;
    localparam logic [18:0] F_SYS   = 19'd1 << 6;
    localparam logic [18:0] F_BP    = 19'd1 << 7;
    localparam logic [18:0] F_OV    = 19'd1 << 8;
    localparam logic [18:0] F_TR    = 19'd1 << 9;
    localparam logic [18:0] F_RDADR = 19'd1 << 10;
    localparam logic [18:0] F_WRADR = 19'd1 << 11;
    localparam logic [18:0] F_WRTLR = 19'd1 << 14;
    localparam logic [18:0] F_MOD   = 19'd1 << 16;
    localparam logic [18:0] F_ERET  = 19'd1 << 17;
    localparam logic [18:0] F_REF   = 19'd1 << 18;

    typedef struct {
        logic [18:0] exc;
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] daddr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        expFlush;
        logic        expRv;
        logic [31:0] expRpc;
        logic [31:0] expEpc;
        logic [31:0] expBadv;
        logic [31:0] expCause;
        logic [31:0] expStatus;
    } VecType;

    VecType vecs[15];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // MEM must never carry a live instruction while a redirect is pending.
    always @(posedge clk) begin
        if (!rst && Redirect_Valid && MEM_Valid) begin
            errors++;
            $display("FAIL mem_valid_during_pending: got 1 expected 0");
        end
    end

    task automatic idleInputs();
        MEM_Valid       = 1'b0;
        MEM_ExceptType  = 19'd0;
        MEM_InDelaySlot = 1'b0;
        WB_CP0We        = 1'b0;
        WB_CP0Addr      = 5'd0;
        WB_CP0Data      = 32'd0;
    endtask

    task automatic setVec(input int i, input logic [18:0] exc, input logic valid,
                          input logic [31:0] pc, input logic ds, input logic [31:0] daddr,
                          input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic expFlush, input logic expRv, input logic [31:0] expRpc,
                          input logic [31:0] expEpc, input logic [31:0] expBadv,
                          input logic [31:0] expCause, input logic [31:0] expStatus);
        vecs[i].exc = exc;       vecs[i].valid = valid;   vecs[i].pc = pc;
        vecs[i].ds = ds;         vecs[i].daddr = daddr;   vecs[i].we = we;
        vecs[i].waddr = waddr;   vecs[i].wdata = wdata;   vecs[i].expFlush = expFlush;
        vecs[i].expRv = expRv;   vecs[i].expRpc = expRpc; vecs[i].expEpc = expEpc;
        vecs[i].expBadv = expBadv; vecs[i].expCause = expCause; vecs[i].expStatus = expStatus;
    endtask

    initial begin
        // Expected values are hand-computed and chained: each row starts
        // from the CP0 state the previous row leaves behind.
        setVec(0,  F_OV, 1, 32'h8000_1000, 0, 32'h0, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_1000, 32'h0, 32'h0000_0030, 32'h2);
        setVec(1,  F_ERET, 1, 32'h8000_2000, 0, 32'h0, 0, 5'd0, 32'h0,
               1, 1, 32'h8000_1000, 32'h8000_1000, 32'h0, 32'h0000_0030, 32'h0);
        setVec(2,  F_RDADR, 1, 32'h8000_1004, 1, 32'h8000_2001, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_1000, 32'h8000_2001, 32'h8000_0010, 32'h2);
        setVec(3,  F_ERET, 1, 32'h8000_2000, 0, 32'h0, 1, 5'd14, 32'h8000_0100,
               1, 1, 32'h8000_0100, 32'h8000_0100, 32'h8000_2001, 32'h8000_0010, 32'h0);
        setVec(4,  F_WRTLR, 1, 32'h8000_4000, 0, 32'h0040_0000, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0200, 32'h8000_4000, 32'h0040_0000, 32'h0000_000C, 32'h2);
        setVec(5,  F_WRTLR, 1, 32'h8000_5000, 1, 32'h0050_0000, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_4000, 32'h0050_0000, 32'h0000_000C, 32'h2);
        setVec(6,  F_INT | F_SYS | F_RDADR, 1, 32'h8000_6000, 0, 32'h1234_5678, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_4000, 32'h0050_0000, 32'h0000_0000, 32'h2);
        setVec(7,  19'd0, 1, 32'h8000_6004, 0, 32'h0, 1, 5'd12, 32'h0,
               0, 0, 32'hBFC0_0380, 32'h8000_4000, 32'h0050_0000, 32'h0000_0000, 32'h0);
        setVec(8,  F_TLBRI, 1, 32'h0000_0000, 1, 32'h0, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0200, 32'hFFFF_FFFC, 32'h0, 32'h8000_0008, 32'h2);
        setVec(9,  F_OV, 0, 32'h8000_9000, 0, 32'h0, 1, 5'd13, 32'hFFFF_FFFF,
               0, 0, 32'hBFC0_0200, 32'hFFFF_FFFC, 32'h0, 32'h8000_0008, 32'h2);
        setVec(10, 19'd0, 1, 32'h8000_9004, 0, 32'h0, 1, 5'd8, 32'hDEAD_BEEF,
               0, 0, 32'hBFC0_0200, 32'hFFFF_FFFC, 32'h0, 32'h8000_0008, 32'h2);
        setVec(11, F_RI | F_CPU | F_SYS, 1, 32'h8000_7000, 0, 32'h0, 1, 5'd12, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_7000, 32'h0, 32'h0000_0028, 32'h2);
`ifdef EXC_REFETCH_EN
        setVec(12, F_REF, 1, 32'h8000_3000, 0, 32'h0, 0, 5'd0, 32'h0,
               1, 1, 32'h8000_3000, 32'h8000_7000, 32'h0, 32'h0000_0028, 32'h2);
`else
        setVec(12, F_REF, 1, 32'h8000_3000, 0, 32'h0, 0, 5'd0, 32'h0,
               0, 0, 32'hBFC0_0380, 32'h8000_7000, 32'h0, 32'h0000_0028, 32'h2);
`endif
        setVec(13, F_BP | F_TR | F_ERET, 1, 32'h8000_8000, 0, 32'h0, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_7000, 32'h0, 32'h0000_0024, 32'h2);
        setVec(14, F_WRADR | F_MOD, 1, 32'h8000_8004, 0, 32'hA000_0004, 0, 5'd0, 32'h0,
               1, 1, 32'hBFC0_0380, 32'h8000_7000, 32'hA000_0004, 32'h0000_0014, 32'h2);

        rst = 1'b1;
        IF_RedirectReady = 1'b0;
        MEM_PC = 32'd0;
        MEM_DataAddr = 32'd0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_flush", {31'd0, Flush_All}, 32'd0);
        check("reset_rv", {31'd0, Redirect_Valid}, 32'd0);
        check("reset_rpc", Redirect_PC, 32'd0);
        check("reset_epc", CP0_EPC, 32'd0);
        check("reset_badv", CP0_BadVAddr, 32'd0);
        check("reset_cause", CP0_Cause, 32'd0);
        check("reset_status", CP0_Status, 32'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            MEM_Valid       = vecs[i].valid;
            MEM_ExceptType  = vecs[i].exc;
            MEM_PC          = vecs[i].pc;
            MEM_InDelaySlot = vecs[i].ds;
            MEM_DataAddr    = vecs[i].daddr;
            WB_CP0We        = vecs[i].we;
            WB_CP0Addr      = vecs[i].waddr;
            WB_CP0Data      = vecs[i].wdata;
            #1;
            check($sformatf("v%0d_flush", i), {31'd0, Flush_All}, {31'd0, vecs[i].expFlush});
            @(posedge clk);
            #1;
            idleInputs();
            check($sformatf("v%0d_rv", i), {31'd0, Redirect_Valid}, {31'd0, vecs[i].expRv});
            check($sformatf("v%0d_rpc", i), Redirect_PC, vecs[i].expRpc);
            check($sformatf("v%0d_epc", i), CP0_EPC, vecs[i].expEpc);
            check($sformatf("v%0d_badv", i), CP0_BadVAddr, vecs[i].expBadv);
            check($sformatf("v%0d_cause", i), CP0_Cause, vecs[i].expCause);
            check($sformatf("v%0d_status", i), CP0_Status, vecs[i].expStatus);
            if (vecs[i].expRv) begin
                IF_RedirectReady = 1'b1;
                @(posedge clk);
                #1;
                IF_RedirectReady = 1'b0;
                check($sformatf("v%0d_rv_drop", i), {31'd0, Redirect_Valid}, 32'd0);
            end
        end

        // Eret with IF stalling the redirect; EXL is 1 from the table.
        @(negedge clk);
        MEM_Valid  = 1'b1;
        WB_CP0We   = 1'b1;
        WB_CP0Addr = 5'd14;
        WB_CP0Data = 32'h8000_0100;
        @(posedge clk);
        #1;
        idleInputs();
        check("eret_setup_rv", {31'd0, Redirect_Valid}, 32'd0);
        check("eret_setup_epc", CP0_EPC, 32'h8000_0100);
        @(negedge clk);
        MEM_Valid      = 1'b1;
        MEM_ExceptType = F_ERET;
        MEM_PC         = 32'h8000_0200;
        #1 check("eret_flush", {31'd0, Flush_All}, 32'd1);
        @(posedge clk);
        #1;
        idleInputs();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("eret_hold%0d_rv", k), {31'd0, Redirect_Valid}, 32'd1);
            check($sformatf("eret_hold%0d_rpc", k), Redirect_PC, 32'h8000_0100);
            check($sformatf("eret_hold%0d_status", k), CP0_Status, 32'd0);
            if (k == 2) IF_RedirectReady = 1'b1;
            @(posedge clk);
            #1;
        end
        IF_RedirectReady = 1'b0;
        check("eret_idle_rv", {31'd0, Redirect_Valid}, 32'd0);

        // New commit accepted in the first IDLE cycle.
        MEM_Valid      = 1'b1;
        MEM_ExceptType = F_OV;
        MEM_PC         = 32'h8000_8000;
        #1 check("backtoback_flush", {31'd0, Flush_All}, 32'd1);
        @(posedge clk);
        #1;
        idleInputs();
        check("backtoback_rv", {31'd0, Redirect_Valid}, 32'd1);
        check("backtoback_epc", CP0_EPC, 32'h8000_8000);
        check("backtoback_rpc", Redirect_PC, 32'hBFC0_0380);
        check("backtoback_cause", CP0_Cause, 32'h0000_0030);

        // Reset while a redirect is pending loses it.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstpend_rv", {31'd0, Redirect_Valid}, 32'd0);
        check("rstpend_rpc", Redirect_PC, 32'd0);
        check("rstpend_epc", CP0_EPC, 32'd0);
        check("rstpend_status", CP0_Status, 32'd0);
        @(negedge clk);
        check("rstpend_flush", {31'd0, Flush_All}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
